// File: rtl/ia_pkg.sv
// Shared definitions for the IA (input activation) sparse bundle path.
// Used by the packer here and by the PE-side consumers of the bundle.
package ia_pkg;

  localparam int CHANNEL = 32;
  localparam int DATA_W  = 16;
  localparam int CIDX_W  = 8;
  localparam int LANES   = 32;

  // Widths of the bundle's len and iters fields
  localparam int LEN_W   = $clog2(CHANNEL) + 1;
  localparam int ITERS_W = LEN_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/ia_iters_calc.sv
// Converts a bundle's nonzero count into the PE iteration count:
// iters = ceil(len/LANES) - 1, with len = 0 mapping to 0.
module ia_iters_calc #(
  parameter int CHANNEL = ia_pkg::CHANNEL,
  parameter int LANES   = ia_pkg::LANES,
  localparam int LEN_W  = $clog2(CHANNEL) + 1
) (
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] iters
);

  localparam int SH = $clog2(LANES);

  logic [31:0] groups;

  // LANES is a power of two, so the division by LANES reduces to a shift
  always_comb begin
    groups = (32'(len) + 32'(LANES - 1)) >> SH;
    iters  = (len == '0) ? '0 : LEN_W'(groups - 32'd1);
  end

endmodule

// File: rtl/ia_sparse_packer.sv
// Packs a dense channel-major activation stream into per-pixel sparse IA
// bundles (values, channel indices, len, iters, coordinates) for the PE array.
module ia_sparse_packer
  import ia_pkg::*;
#(
  parameter int CHANNEL = ia_pkg::CHANNEL,
  parameter int DATA_W  = ia_pkg::DATA_W,
  parameter int CIDX_W  = ia_pkg::CIDX_W,
  parameter int ROWS    = 32,
  parameter int COLS    = 32,
  parameter int LANES   = ia_pkg::LANES,
  parameter int RELU_EN = 0,
  localparam int H_W    = $clog2(ROWS) + 1,
  localparam int W_W    = $clog2(COLS) + 1,
  localparam int LEN_W  = $clog2(CHANNEL) + 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic signed [DATA_W-1:0]         i_in_data,
  output logic                             o_bundle_valid,
  input  logic                             i_bundle_ready,
  output logic [H_W-1:0]                   o_ia_h,
  output logic [W_W-1:0]                   o_ia_w,
  output logic [CHANNEL-1:0][DATA_W-1:0]   o_ia_data,
  output logic [CHANNEL-1:0][CIDX_W-1:0]   o_ia_c_idx,
  output logic [LEN_W-1:0]                 o_ia_len,
  output logic [LEN_W-1:0]                 o_ia_iters,
  output logic                             o_frame_done,
  output logic                             o_busy
);

  localparam int CIW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  state_t                           state_q, state_d;
  logic [LEN_W-1:0]                 ch_cnt_q, slot_q, len_q, iters_q;
  logic [LEN_W-1:0]                 len_d, iters_d;
  logic [H_W-1:0]                   h_q;
  logic [W_W-1:0]                   w_q;
  logic [CHANNEL-1:0][DATA_W-1:0]   data_q;
  logic [CHANNEL-1:0][CIDX_W-1:0]   cidx_q;
  logic                             done_q;
  logic                             fire_in, fire_out, keep, last_ch, last_pix;
  logic                             frame_start, clear;

  always_comb begin
    fire_in     = (state_q == S_FILL) && i_in_valid;
    fire_out    = (state_q == S_HOLD) && i_bundle_ready;
    frame_start = (state_q == S_IDLE) && i_start;
    keep        = (i_in_data != '0) && !((RELU_EN != 0) && i_in_data[DATA_W-1]);
    last_ch     = (ch_cnt_q == LEN_W'(CHANNEL - 1));
    last_pix    = (h_q == H_W'(ROWS - 1)) && (w_q == W_W'(COLS - 1));
    // len as it will be after this cycle's write, so the last channel counts
    len_d       = slot_q + LEN_W'(keep);
  end

  ia_iters_calc #(
    .CHANNEL (CHANNEL),
    .LANES   (LANES)
  ) u_iters (
    .len   (len_d),
    .iters (iters_d)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FILL;
          clear   = 1'b1;
        end
      end
      S_FILL: begin
        if (fire_in && last_ch) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (fire_out) begin
          if (last_pix) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
            clear   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_cnt_q <= '0;
      slot_q   <= '0;
      len_q    <= '0;
      iters_q  <= '0;
      h_q      <= '0;
      w_q      <= '0;
      data_q   <= '0;
      cidx_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fire_out && last_pix;

      // Zeroing the arrays on every new pixel keeps slots >= len at 0
      if (clear) begin
        ch_cnt_q <= '0;
        slot_q   <= '0;
        data_q   <= '0;
        cidx_q   <= '0;
      end else if (fire_in) begin
        ch_cnt_q <= ch_cnt_q + 1'b1;
        if (keep) begin
          data_q[slot_q[CIW-1:0]] <= i_in_data;
          cidx_q[slot_q[CIW-1:0]] <= CIDX_W'(ch_cnt_q);
          slot_q                  <= len_d;
        end
        if (last_ch) begin
          len_q   <= len_d;
          iters_q <= iters_d;
        end
      end

      if (frame_start) begin
        h_q <= '0;
        w_q <= '0;
      end else if (fire_out) begin
        if (w_q == W_W'(COLS - 1)) begin
          w_q <= '0;
          h_q <= h_q + 1'b1;
        end else begin
          w_q <= w_q + 1'b1;
        end
      end
    end
  end

  assign o_in_ready     = (state_q == S_FILL);
  assign o_bundle_valid = (state_q == S_HOLD);
  assign o_busy         = (state_q != S_IDLE);
  assign o_frame_done   = done_q;
  assign o_ia_h         = h_q;
  assign o_ia_w         = w_q;
  assign o_ia_data      = data_q;
  assign o_ia_c_idx     = cidx_q;
  assign o_ia_len       = len_q;
  assign o_ia_iters     = iters_q;

endmodule

// File: tb/tb_ia_sparse_packer.sv
// Bench for ia_sparse_packer: two instances (RELU off / on) share one stimulus
// stream; bundles are checked against a filter-and-count model of each pixel.
module tb_ia_sparse_packer;

  localparam int CH   = 8;
  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int LN   = 4;
  localparam int ROWS = 1;
  localparam int COLS = 2;
  localparam int LW   = $clog2(CH) + 1;
  localparam int HW   = $clog2(ROWS) + 1;
  localparam int WW   = $clog2(COLS) + 1;

  typedef logic [DW-1:0] pix_t [CH];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic bundle_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic                       rdy   [2];
  logic                       bv    [2];
  logic                       done  [2];
  logic                       busy  [2];
  logic [HW-1:0]              ia_h  [2];
  logic [WW-1:0]              ia_w  [2];
  logic [CH-1:0][DW-1:0]      ia_d  [2];
  logic [CH-1:0][CW-1:0]      ia_c  [2];
  logic [LW-1:0]              ia_len[2];
  logic [LW-1:0]              ia_it [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ia_sparse_packer #(
      .CHANNEL (CH), .DATA_W (DW), .CIDX_W (CW), .ROWS (ROWS), .COLS (COLS),
      .LANES (LN), .RELU_EN (g)
    ) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_in_valid     (in_valid),
      .o_in_ready     (rdy[g]),
      .i_in_data      (in_data),
      .o_bundle_valid (bv[g]),
      .i_bundle_ready (bundle_ready),
      .o_ia_h         (ia_h[g]),
      .o_ia_w         (ia_w[g]),
      .o_ia_data      (ia_d[g]),
      .o_ia_c_idx     (ia_c[g]),
      .o_ia_len       (ia_len[g]),
      .o_ia_iters     (ia_it[g]),
      .o_frame_done   (done[g]),
      .o_busy         (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep the nonzero (and, with relu, non-negative) values in order
  task automatic check_bundle(input pix_t v, input int h, input int w, input string tag);
    logic [DW-1:0] ed [CH];
    logic [CW-1:0] ec [CH];
    int n, it;
    for (int d = 0; d < 2; d++) begin
      n = 0;
      for (int k = 0; k < CH; k++) begin
        ed[k] = '0;
        ec[k] = '0;
      end
      for (int k = 0; k < CH; k++) begin
        if (v[k] != 0 && !(d == 1 && $signed(v[k]) < 0)) begin
          ed[n] = v[k];
          ec[n] = CW'(k);
          n++;
        end
      end
      it = (n == 0) ? 0 : (n + LN - 1) / LN - 1;
      chk($sformatf("%s r%0d valid", tag, d), 32'(bv[d]), 32'd1);
      chk($sformatf("%s r%0d len", tag, d), 32'(ia_len[d]), 32'(n));
      chk($sformatf("%s r%0d iters", tag, d), 32'(ia_it[d]), 32'(it));
      chk($sformatf("%s r%0d h", tag, d), 32'(ia_h[d]), 32'(h));
      chk($sformatf("%s r%0d w", tag, d), 32'(ia_w[d]), 32'(w));
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("%s r%0d data[%0d]", tag, d, k), 32'(ia_d[d][k]), 32'(ed[k]));
        chk($sformatf("%s r%0d cidx[%0d]", tag, d, k), 32'(ia_c[d][k]), 32'(ec[k]));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s r%0d in_ready", tag, d), 32'(rdy[d]), 32'd0);
      chk($sformatf("%s r%0d bvalid", tag, d), 32'(bv[d]), 32'd0);
      chk($sformatf("%s r%0d done", tag, d), 32'(done[d]), 32'd0);
      chk($sformatf("%s r%0d busy", tag, d), 32'(busy[d]), 32'd0);
      chk($sformatf("%s r%0d len", tag, d), 32'(ia_len[d]), 32'd0);
      chk($sformatf("%s r%0d iters", tag, d), 32'(ia_it[d]), 32'd0);
      chk($sformatf("%s r%0d h", tag, d), 32'(ia_h[d]), 32'd0);
      chk($sformatf("%s r%0d w", tag, d), 32'(ia_w[d]), 32'd0);
      chk($sformatf("%s r%0d data", tag, d), 32'(ia_d[d] != '0), 32'd0);
      chk($sformatf("%s r%0d cidx", tag, d), 32'(ia_c[d] != '0), 32'd0);
    end
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s busy", tag), 32'(busy[0]), 32'd1);
    chk($sformatf("%s in_ready", tag), 32'(rdy[0]), 32'd1);
  endtask

  // Feed n channels; gaps drop valid at random and drive junk on idle cycles
  task automatic send_pixel(input pix_t v, input int n, input bit gaps, input string tag);
    int i, cyc;
    bit b;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rdy[0]) begin
        if (gaps) b = 1'($urandom_range(0, 1));
        else      b = 1'b1;
        in_valid = b;
        in_data  = b ? v[i] : DW'($urandom);
        if (b) i++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    chk($sformatf("%s channels fed", tag), 32'(i), 32'(n));
  endtask

  task automatic accept();
    bundle_ready = 1'b1;
    @(negedge clk);
    bundle_ready = 1'b0;
  endtask

  task automatic frame_end(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s r%0d done", tag, d), 32'(done[d]), 32'd1);
      chk($sformatf("%s r%0d busy", tag, d), 32'(busy[d]), 32'd0);
      chk($sformatf("%s r%0d bvalid", tag, d), 32'(bv[d]), 32'd0);
      chk($sformatf("%s r%0d in_ready", tag, d), 32'(rdy[d]), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("%s done pulse width", tag), 32'(done[0] | done[1]), 32'd0);
  endtask

  function automatic pix_t rand_pix();
    pix_t r;
    for (int k = 0; k < CH; k++) begin
      if ($urandom_range(0, 1) == 1) r[k] = '0;
      else r[k] = DW'($urandom_range(0, 200)) - DW'(100);
    end
    return r;
  endfunction

  initial begin
    pix_t p_a, p_z, p_f, p_r, p_s;
    p_a = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'hFFFD, 16'h0000, 16'h0007, 16'h0000};
    p_z = '{default: '0};
    p_f = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Frame 1: sample stream, long back-pressure, then an all-zero pixel
    start_frame("f1 start");
    send_pixel(p_a, CH, 1'b0, "f1p0");
    check_bundle(p_a, 0, 0, "f1p0");
    in_valid = 1'b1;
    start    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      chk($sformatf("hold%0d in_ready", c), 32'(rdy[0]), 32'd0);
      check_bundle(p_a, 0, 0, $sformatf("hold%0d", c));
    end
    in_valid = 1'b0;
    start    = 1'b0;
    accept();
    send_pixel(p_z, CH, 1'b0, "f1p1");
    check_bundle(p_z, 0, 1, "f1p1");
    accept();
    frame_end("f1 end");

    // Frame 2: full pixel, then a random pixel with input gaps
    start_frame("f2 start");
    send_pixel(p_f, CH, 1'b0, "f2p0");
    check_bundle(p_f, 0, 0, "f2p0");
    accept();
    p_r = rand_pix();
    send_pixel(p_r, CH, 1'b1, "f2p1");
    check_bundle(p_r, 0, 1, "f2p1");
    accept();
    frame_end("f2 end");

    // Frame 3: sample stream again with gaps must give the same bundle
    start_frame("f3 start");
    send_pixel(p_a, CH, 1'b1, "f3p0");
    check_bundle(p_a, 0, 0, "f3p0");
    accept();
    p_r = rand_pix();
    send_pixel(p_r, CH, 1'b1, "f3p1");
    check_bundle(p_r, 0, 1, "f3p1");
    accept();
    frame_end("f3 end");

    // Asynchronous reset mid-pixel, then a clean frame
    start_frame("f4 start");
    send_pixel(p_a, 4, 1'b0, "f4 partial");
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    start_frame("f5 start");
    p_r = rand_pix();
    send_pixel(p_r, CH, 1'b0, "f5p0");
    check_bundle(p_r, 0, 0, "f5p0");
    accept();
    p_s = rand_pix();
    send_pixel(p_s, CH, 1'b1, "f5p1");
    check_bundle(p_s, 0, 1, "f5p1");
    accept();
    frame_end("f5 end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
